// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - request/response handshake and memory strobe bundle for mem_ctrl
interface mem_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_we;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic              mem_rd;
  logic              mem_wrt;
  logic [ADDR_W-1:0] mem_addr;

  // CPU datapath side: issues requests, observes responses and memory strobes
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata, busy, mem_rd, mem_wrt, mem_addr
  );

  // controller side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_we, rsp_rdata, busy, mem_rd, mem_wrt, mem_addr
  );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - load/store bus initiator for the 32x8 data memory; MEM_CTRL_TURNAROUND_EN adds a bus-idle cycle before a store that follows a load
module mem_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int FIFO_D = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_ctrl_if.slave         bus,
  inout  wire  [DATA_W-1:0] data_bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_D,
    S_WR
`ifdef MEM_CTRL_TURNAROUND_EN
    , S_TURN
`endif
  } state_t;

  state_t            state_q, state_d;

  logic              fifo_we_q    [FIFO_D];
  logic [ADDR_W-1:0] fifo_addr_q  [FIFO_D];
  logic [DATA_W-1:0] fifo_wdata_q [FIFO_D];
  logic              fifo_we_d    [FIFO_D];
  logic [ADDR_W-1:0] fifo_addr_d  [FIFO_D];
  logic [DATA_W-1:0] fifo_wdata_d [FIFO_D];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_we_q, rsp_we_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              push, pop;
  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic              rd_en, wrt_en, bus_oe;

  assign push       = bus.req_valid && bus.req_ready;
  assign head_we    = fifo_we_q[rd_ptr_q];
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_wdata = fifo_wdata_q[rd_ptr_q];

  // state register; reset discards any in-flight command
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next state: IDLE, RD_D and WR all launch the buffered head directly, so chained commands see no idle gap
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_RD_A: state_d = S_RD_D;
`ifdef MEM_CTRL_TURNAROUND_EN
      S_TURN: state_d = S_WR;
`endif
      default: begin
        state_d = S_IDLE;
        if (count_q != 2'd0) begin
          pop = 1'b1;
          if (!head_we)                state_d = S_RD_A;
`ifdef MEM_CTRL_TURNAROUND_EN
          else if (state_q == S_RD_D)  state_d = S_TURN;
`endif
          else                         state_d = S_WR;
        end
      end
    endcase
  end

  // outputs decoded from state; the master drives the data bus only while writing
  always_comb begin
    rd_en  = 1'b0;
    wrt_en = 1'b0;
    bus_oe = 1'b0;
    case (state_q)
      S_RD_A, S_RD_D: rd_en = 1'b1;
      S_WR: begin
        wrt_en = 1'b1;
        bus_oe = 1'b1;
      end
      default: ;
    endcase
  end

  // request buffer, command register and response datapath
  always_comb begin
    fifo_we_d    = fifo_we_q;
    fifo_addr_d  = fifo_addr_q;
    fifo_wdata_d = fifo_wdata_q;
    wr_ptr_d     = wr_ptr_q;
    if (push) begin
      fifo_we_d[wr_ptr_q]    = bus.req_we;
      fifo_addr_d[wr_ptr_q]  = bus.req_addr;
      fifo_wdata_d[wr_ptr_q] = bus.req_wdata;
      wr_ptr_d               = ~wr_ptr_q;
    end
    rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q + 2'(push) - 2'(pop);

    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    if (pop) begin
      cmd_we_d    = head_we;
      cmd_addr_d  = head_addr;
      cmd_wdata_d = head_wdata;
    end

    // the address only moves when a strobe phase starts, so it holds through IDLE and TURN
    mem_addr_d = mem_addr_q;
    if (state_d == S_RD_A || state_d == S_WR)
      mem_addr_d = pop ? head_addr : cmd_addr_q;

    rsp_valid_d = (state_q == S_RD_D) || (state_q == S_WR);
    rsp_we_d    = rsp_valid_d && cmd_we_q;
    rsp_rdata_d = (state_q == S_RD_D) ? data_bus : rsp_rdata_q;
  end

  // control and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // buffer storage needs no reset; count gates every read of it
  always_ff @(posedge clk) begin
    fifo_we_q    <= fifo_we_d;
    fifo_addr_q  <= fifo_addr_d;
    fifo_wdata_q <= fifo_wdata_d;
  end

  assign bus.req_ready = (count_q < 2'(FIFO_D));
  assign bus.busy      = (state_q != S_IDLE) || (count_q != 2'd0);
  assign bus.mem_rd    = rd_en;
  assign bus.mem_wrt   = wrt_en;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_we    = rsp_we_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign data_bus      = bus_oe ? cmd_wdata_q : 'z;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed and randomized checks of mem_ctrl against a memory array and response scoreboard
module tb_mem_ctrl;
  localparam int AW = 5;
  localparam int DW = 8;
`ifdef MEM_CTRL_TURNAROUND_EN
  localparam int TURN_CYC = 1;
`else
  localparam int TURN_CYC = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  wire [DW-1:0] data_bus;

  mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FIFO_D(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .data_bus (data_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // memory: registered read output, drives the bus only while read strobe is held after its output updates
  logic [7:0] mem_arr [32];
  logic [7:0] mem_q;
  logic       mem_oe_q;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem_arr[i] <= init_val(i);
      mem_q    <= 8'd0;
      mem_oe_q <= 1'b0;
    end else begin
      if (bus.mem_wrt) mem_arr[bus.mem_addr] <= data_bus;
      if (bus.mem_rd)  mem_q <= mem_arr[bus.mem_addr];
      mem_oe_q <= bus.mem_rd;
    end
  end
  assign data_bus = (bus.mem_rd && mem_oe_q) ? mem_q : 'z;

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] data;
    int         acc_cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         lat_q[$];
  int         rsp_cyc_q[$];
  logic [7:0] ref_mem [32];
  logic [7:0] last_rdata;
  int total = 0, passed = 0, fails = 0;
  int cyc = 0, viol = 0, rd_cycles = 0, wr_cycles = 0, last_rd_cyc = 0, wr_gap = 0, stall_cycles = 0;
  logic acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // one clock: observe the cycle at the falling edge, then apply the model's view of the rising edge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.mem_rd && bus.mem_wrt) viol++;
    if (bus.mem_rd) begin
      rd_cycles++;
      last_rd_cyc = cyc;
    end
    if (bus.mem_wrt) begin
      wr_cycles++;
      wr_gap = cyc - last_rd_cyc;
    end
    if (bus.req_valid && !bus.req_ready) stall_cycles++;
    if (bus.rsp_valid) begin
      check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_we", 32'(bus.rsp_we), 32'(e.we));
        if (e.we) check("rsp_rdata_hold", 32'(bus.rsp_rdata), 32'(last_rdata));
        else begin
          check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.data));
          last_rdata = e.data;
        end
        lat_q.push_back(cyc - e.acc_cyc);
        rsp_cyc_q.push_back(cyc);
      end
    end
    if (bus.mem_rd || bus.mem_wrt) begin
      if (exp_q.size() == 0) viol++;
      else if (bus.mem_addr !== exp_q[0].addr) viol++;
    end
    if (bus.mem_wrt && (exp_q.size() == 0 || data_bus !== exp_q[0].data)) viol++;
    if ((bus.mem_wrt || (bus.mem_rd && mem_oe_q)) && $isunknown(data_bus)) viol++;
    acc = bus.req_valid && bus.req_ready;
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      last_rdata = 8'd0;
      for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    end else if (acc) begin
      e.we      = bus.req_we;
      e.addr    = bus.req_addr;
      e.acc_cyc = cyc;
      if (bus.req_we) begin
        e.data = bus.req_wdata;
        ref_mem[bus.req_addr] = bus.req_wdata;
      end else begin
        e.data = ref_mem[bus.req_addr];
      end
      exp_q.push_back(e);
    end
    #1;
  endtask

  task automatic send(input logic we, input logic [4:0] addr, input logic [7:0] wdata);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    do begin
      tick();
      n++;
    end while (!acc && n < 20);
    check("send_accept", 32'(acc), 32'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bus.req_valid = 1'b0;
    while ((exp_q.size() != 0 || bus.busy) && n < 60) begin
      tick();
      n++;
    end
    check(tag, 32'(n < 60), 32'd1);
    tick();
    tick();
  endtask

  task automatic clear_logs();
    lat_q.delete();
    rsp_cyc_q.delete();
    rd_cycles    = 0;
    wr_cycles    = 0;
    stall_cycles = 0;
    wr_gap       = 0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_mem_rd"},    32'(bus.mem_rd),    32'd0);
    check({pfx, "_mem_wrt"},   32'(bus.mem_wrt),   32'd0);
    check({pfx, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    check({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({pfx, "_rsp_we"},    32'(bus.rsp_we),    32'd0);
    check({pfx, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'd0);
    check({pfx, "_busy"},      32'(bus.busy),      32'd0);
    check({pfx, "_req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    int acc_n;
    int budget;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("init");

    // store addr 5 then load addr 5
    clear_logs();
    send(1'b1, 5'd5, 8'hA7);
    send(1'b0, 5'd5, 8'h00);
    drain("t1_drain");
    check("t1_rsp_count", 32'(lat_q.size()), 32'd2);
    check("t1_store_lat", 32'(lat_q[0]), 32'd2);
    check("t1_load_lat", 32'(lat_q[1]), 32'd3);
    check("t1_rdata", 32'(bus.rsp_rdata), 32'hA7);
    check("t1_rd_cycles", 32'(rd_cycles), 32'd2);
    check("t1_wr_cycles", 32'(wr_cycles), 32'd1);

    // backpressure: loads 0..3 with valid held high
    clear_logs();
    for (int a = 0; a < 4; a++) send(1'b0, 5'(a), 8'h00);
    drain("t2_drain");
    check("t2_rsp_count", 32'(rsp_cyc_q.size()), 32'd4);
    check("t2_stall_cycles", 32'(stall_cycles), 32'd1);
    check("t2_first_lat", 32'(lat_q[0]), 32'd3);
    for (int i = 1; i < 4; i++) check("t2_spacing", 32'(rsp_cyc_q[i] - rsp_cyc_q[i-1]), 32'd2);

    // push and pop on the same edge at count 1
    clear_logs();
    send(1'b0, 5'd6, 8'h00);
    send(1'b0, 5'd7, 8'h00);
    check("t3_ready_count1", 32'(bus.req_ready), 32'd1);
    send(1'b0, 5'd8, 8'h00);
    check("t3_ready_count2", 32'(bus.req_ready), 32'd0);
    drain("t3_drain");
    check("t3_rsp_count", 32'(lat_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) check("t3_lat", 32'(lat_q[i]), 32'(3 + i));

    // load then store to the same address, then read it back
    clear_logs();
    send(1'b0, 5'd3, 8'h00);
    send(1'b1, 5'd3, 8'h5C);
    send(1'b0, 5'd3, 8'h00);
    drain("t4_drain");
    check("t4_rsp_count", 32'(lat_q.size()), 32'd3);
    check("t4_rd_to_wr_gap", 32'(wr_gap), 32'(1 + TURN_CYC));
    check("t4_store_lat", 32'(lat_q[1]), 32'(3 + TURN_CYC));
    check("t4_readback", 32'(bus.rsp_rdata), 32'h5C);

    // random mix of 200 accepted loads/stores over a small address window
    acc_n  = 0;
    budget = 0;
    while (acc_n < 200 && budget < 3000) begin
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_we    = 1'($urandom_range(0, 1));
      bus.req_addr  = 5'($urandom_range(0, 7));
      bus.req_wdata = 8'($urandom);
      tick();
      budget++;
      if (acc) acc_n++;
    end
    check("t5_accepted", 32'(acc_n), 32'd200);
    drain("t5_drain");
    check("t5_viol", 32'(viol), 32'd0);

    // reset for two cycles while a load sits in RD_D
    send(1'b0, 5'd9, 8'h00);
    tick();
    tick();
    check("t6_pre_rd", 32'(bus.mem_rd), 32'd1);
    check("t6_pre_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("t6");
    rst = 1'b0;
    tick();
    tick();
    check("t6_idle_after", 32'(bus.busy), 32'd0);
    clear_logs();
    send(1'b0, 5'd9, 8'h00);
    drain("t6_drain");
    check("t6_resume_rdata", 32'(bus.rsp_rdata), 32'(init_val(9)));
    check("final_viol", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
